// File: rtl/button_conditioner.sv
// Conditions three raw pushbuttons into single-cycle game commands:
// synchronise, debounce, then left/right auto-repeat with conflict lockout.

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic stable_next
);

  localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic        s1;
  logic        s2;
  logic [23:0] cnt;
  logic [23:0] cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= stable_next;
      cnt    <= cnt_next;
    end
  end

  // stable_next is exported so the consumer can register its pulse on the
  // same edge that the debounced level changes.
  always_comb begin
    stable_next = stable;
    cnt_next    = '0;
    if (s2 != stable) begin
      if (cnt == CNT_LAST) begin
        stable_next = s2;
      end else begin
        cnt_next = cnt + 24'd1;
      end
    end
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 10000000,
  parameter int REPEAT_PERIOD   = 3750000
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       btn_drop_raw,
  output logic       move_left,
  output logic       move_right,
  output logic       drop_piece,
  output logic [1:0] move_state
);

  localparam logic [23:0] REP_LAST   = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] REP_RELOAD = 24'(REPEAT_DELAY - REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_L   = 2'd1,
    HOLD_R   = 2'd2,
    CONFLICT = 2'd3
  } move_state_t;

  logic left_stable;
  logic left_next;
  logic right_stable;
  logic right_next;
  logic drop_stable;
  logic drop_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk         (clk_25MHz),
    .rst         (rst),
    .raw         (btn_left_raw),
    .stable      (left_stable),
    .stable_next (left_next)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk         (clk_25MHz),
    .rst         (rst),
    .raw         (btn_right_raw),
    .stable      (right_stable),
    .stable_next (right_next)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_drop (
    .clk         (clk_25MHz),
    .rst         (rst),
    .raw         (btn_drop_raw),
    .stable      (drop_stable),
    .stable_next (drop_next)
  );

  move_state_t state;
  move_state_t state_next;
  logic [23:0] rep_cnt;
  logic [23:0] rep_next;
  logic        left_pulse;
  logic        right_pulse;

  assign move_state = state;

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rep_cnt    <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      drop_piece <= 1'b0;
    end else begin
      state      <= state_next;
      rep_cnt    <= rep_next;
      move_left  <= left_pulse;
      move_right <= right_pulse;
      drop_piece <= drop_next & ~drop_stable;
    end
  end

  // Both buttons held always wins; a button still held when the conflict
  // clears must be released and re-pressed before it moves again.
  always_comb begin
    state_next  = state;
    rep_next    = rep_cnt;
    left_pulse  = 1'b0;
    right_pulse = 1'b0;
    if (left_next && right_next) begin
      state_next = CONFLICT;
      rep_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          rep_next = '0;
          if (left_next && !left_stable) begin
            state_next = HOLD_L;
            left_pulse = 1'b1;
          end else if (right_next && !right_stable) begin
            state_next  = HOLD_R;
            right_pulse = 1'b1;
          end
        end
        HOLD_L: begin
          if (!left_next) begin
            state_next = IDLE;
            rep_next   = '0;
          end else if (rep_cnt == REP_LAST) begin
            left_pulse = 1'b1;
            rep_next   = REP_RELOAD;
          end else begin
            rep_next = rep_cnt + 24'd1;
          end
        end
        HOLD_R: begin
          if (!right_next) begin
            state_next = IDLE;
            rep_next   = '0;
          end else if (rep_cnt == REP_LAST) begin
            right_pulse = 1'b1;
            rep_next    = REP_RELOAD;
          end else begin
            rep_next = rep_cnt + 24'd1;
          end
        end
        default: begin
          rep_next = '0;
          if (!left_next && !right_next) begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a window-based debounce model and
// a hold-time repeat model are compared every cycle, plus literal pulse lists.

module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  localparam int M_IDLE = 0;
  localparam int M_LEFT = 1;
  localparam int M_RIGHT = 2;
  localparam int M_BLOCK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bl  = 1'b0;
  logic       br  = 1'b0;
  logic       bd  = 1'b0;
  logic       move_left;
  logic       move_right;
  logic       drop_piece;
  logic [1:0] move_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_25MHz     (clk),
    .rst           (rst),
    .btn_left_raw  (bl),
    .btn_right_raw (br),
    .btn_drop_raw  (bd),
    .move_left     (move_left),
    .move_right    (move_right),
    .drop_piece    (drop_piece),
    .move_state    (move_state)
  );

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // A level is accepted once D consecutive samples (ending two edges back,
  // through the synchroniser) all disagree with the current level.
  bit st [3];
  bit samp [3][16];
  int nvalid;
  bit nst [3];
  bit raw_now [3];
  bit all_diff;
  int mode;
  int t0;
  int d;
  bit exp_l, exp_r, exp_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        st[b] = 1'b0;
        for (int j = 0; j < 16; j++) samp[b][j] = 1'b0;
      end
      nvalid = 0;
      mode   = M_IDLE;
      t0     = 0;
      exp_l  = 1'b0;
      exp_r  = 1'b0;
      exp_d  = 1'b0;
    end else begin
      raw_now[0] = bl;
      raw_now[1] = br;
      raw_now[2] = bd;
      for (int b = 0; b < 3; b++) begin
        nst[b] = st[b];
        if (nvalid >= D + 1) begin
          all_diff = 1'b1;
          for (int j = 1; j <= D; j++)
            if (samp[b][j] == st[b]) all_diff = 1'b0;
          if (all_diff) nst[b] = !st[b];
        end
        for (int j = 15; j > 0; j--) samp[b][j] = samp[b][j-1];
        samp[b][0] = raw_now[b];
      end
      if (nvalid < 15) nvalid++;

      exp_d = nst[2] && !st[2];
      exp_l = 1'b0;
      exp_r = 1'b0;
      d = cyc - t0;
      if (nst[0] && nst[1]) begin
        mode = M_BLOCK;
      end else begin
        case (mode)
          M_IDLE: begin
            if (nst[0] && !st[0]) begin
              mode = M_LEFT; t0 = cyc; exp_l = 1'b1;
            end else if (nst[1] && !st[1]) begin
              mode = M_RIGHT; t0 = cyc; exp_r = 1'b1;
            end
          end
          M_LEFT: begin
            if (!nst[0]) mode = M_IDLE;
            else if (d == RD || (d > RD && (d - RD) % RP == 0)) exp_l = 1'b1;
          end
          M_RIGHT: begin
            if (!nst[1]) mode = M_IDLE;
            else if (d == RD || (d > RD && (d - RD) % RP == 0)) exp_r = 1'b1;
          end
          default: begin
            if (!nst[0] && !nst[1]) mode = M_IDLE;
          end
        endcase
      end
      for (int b = 0; b < 3; b++) st[b] = nst[b];
    end
  end

  // ---------------- scoreboard / compare ----------------
  int q_l[$], q_r[$], q_d[$];
  int m_l[$], m_r[$], m_d[$];

  always @(negedge clk) begin
    check_int("move_left vs model", move_left, exp_l);
    check_int("move_right vs model", move_right, exp_r);
    check_int("drop_piece vs model", drop_piece, exp_d);
    check_int("move exclusive", move_left & move_right, 0);
    if (move_left)  q_l.push_back(cyc);
    if (move_right) q_r.push_back(cyc);
    if (drop_piece) q_d.push_back(cyc);
    if (exp_l) m_l.push_back(cyc);
    if (exp_r) m_r.push_back(cyc);
    if (exp_d) m_d.push_back(cyc);
  end

  task automatic clear_lists();
    q_l.delete(); q_r.delete(); q_d.delete();
    m_l.delete(); m_r.delete(); m_d.delete();
  endtask

  task automatic check_pulses(input string name, input int sel, input int base,
                              input int n, input int offs[8]);
    int got[$];
    int mdl[$];
    case (sel)
      0: begin got = q_l; mdl = m_l; end
      1: begin got = q_r; mdl = m_r; end
      default: begin got = q_d; mdl = m_d; end
    endcase
    check_int({name, " dut count"}, got.size(), n);
    check_int({name, " model count"}, mdl.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) check_int({name, " dut offset"}, got[i] - base, offs[i]);
      if (i < mdl.size()) check_int({name, " model offset"}, mdl[i] - base, offs[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  int e0;
  int k;

  initial begin
    idle(3);
    check_int("reset move_left", move_left, 0);
    check_int("reset move_right", move_right, 0);
    check_int("reset drop_piece", drop_piece, 0);
    rst = 1'b0;
    idle(10);

    // Clean drop press held 50 cycles: one pulse after edge 5, none on release.
    clear_lists();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) e0 = cyc + 1;
      bd = 1'b1;
    end
    @(negedge clk);
    bd = 1'b0;
    idle(20);
    check_pulses("drop", 2, e0, 1, '{5, 0, 0, 0, 0, 0, 0, 0});
    check_int("drop no moves", q_l.size() + q_r.size(), 0);

    // Left bounces on edges 0..9, clean from edge 10: single pulse at 15.
    clear_lists();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) e0 = cyc + 1;
      bl = (i >= 10) ? 1'b1 : ((i % 2) == 0);
    end
    @(negedge clk);
    bl = 1'b0;
    idle(20);
    check_pulses("bounce left", 0, e0, 1, '{15, 0, 0, 0, 0, 0, 0, 0});
    check_int("bounce no drop/right", q_d.size() + q_r.size(), 0);

    // Right held: initial pulse then repeats at +10 and every 3 after.
    clear_lists();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) e0 = cyc + 1;
      br = 1'b1;
    end
    @(negedge clk);
    br = 1'b0;
    idle(20);
    check_pulses("repeat right", 1, e0, 8, '{5, 15, 18, 21, 24, 27, 30, 33});
    check_int("repeat no left", q_l.size(), 0);

    // Simultaneous press locks out; lone left after conflict stays silent.
    clear_lists();
    @(negedge clk);
    bl = 1'b1;
    br = 1'b1;
    idle(20);
    br = 1'b0;
    idle(20);
    bl = 1'b0;
    idle(20);
    check_int("conflict no pulses", q_l.size() + q_r.size(), 0);
    check_int("conflict model no pulses", m_l.size() + m_r.size(), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) e0 = cyc + 1;
      bl = 1'b1;
    end
    @(negedge clk);
    bl = 1'b0;
    idle(20);
    check_pulses("post-conflict left", 0, e0, 1, '{5, 0, 0, 0, 0, 0, 0, 0});
    check_int("post-conflict no right", q_r.size(), 0);

    // Asynchronous reset during a repeat pulse with left still held.
    clear_lists();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) e0 = cyc + 1;
      bl = 1'b1;
    end
    @(posedge clk);
    #3;
    check_int("pre-reset repeat pulse", move_left, 1);
    rst = 1'b1;
    #1;
    check_int("async reset move_left", move_left, 0);
    check_int("async reset move_right", move_right, 0);
    check_int("async reset drop_piece", drop_piece, 0);
    idle(3);
    check_pulses("pre-reset left", 0, e0, 1, '{5, 0, 0, 0, 0, 0, 0, 0});
    clear_lists();
    rst = 1'b0;
    k = cyc + 1;
    idle(20);
    bl = 1'b0;
    idle(20);
    check_pulses("post-reset left", 0, k, 5, '{5, 15, 18, 21, 24, 0, 0, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000 (10 ms at 25 MHz); consecutive stable cycles needed to accept a level change; legal range 2..2^24-1.
REQ-002 Parameter REPEAT_DELAY, default 10000000 (400 ms); cycles from first move pulse to first auto-repeat pulse; legal range 2..2^24-1.
REQ-003 Parameter REPEAT_PERIOD, default 3750000 (150 ms); cycles between auto-repeat pulses; legal range 2..2^24-1.
REQ-004 clk_25MHz  input  1  sole clock, 25 MHz pixel clock shared with the display/game logic.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_left_raw / btn_right_raw / btn_drop_raw  input  1 each  raw asynchronous pushbuttons, active-high, may bounce.
REQ-007 move_left / move_right / drop_piece  output  1 each  registered single-cycle command pulses to the game logic.

Function
REQ-008 Each raw input SHALL pass through its own 2-flop synchronizer (s1, s2) before any other use.
REQ-009 Each button SHALL keep a debounced level "stable" and a 24-bit debounce counter.
REQ-010 Cycle with s2 == stable: counter SHALL clear to 0.
REQ-011 Cycle with s2 != stable and counter < DEBOUNCE_CYCLES-1: counter SHALL increment.
REQ-012 Cycle with s2 != stable and counter == DEBOUNCE_CYCLES-1: stable SHALL take s2 and counter SHALL clear on that edge.
REQ-013 Latency: if edge k is the first edge sampling a clean raw high, stable SHALL rise at edge k+DEBOUNCE_CYCLES+1; a clean release SHALL take the same latency to clear stable.
REQ-014 Any bounce (s2 returning to stable) before acceptance SHALL restart the count from 0; no pulse SHALL result.
REQ-015 drop_piece SHALL be high for exactly one cycle after the edge at which drop stable rises; never on release; no auto-repeat.
REQ-016 Move FSM states: IDLE, HOLD_L, HOLD_R, CONFLICT; one shared 24-bit repeat counter.
REQ-017 IDLE -> HOLD_L on left stable rise with right stable low: move_left pulses one cycle after that edge; repeat counter loads 0.
REQ-018 IDLE -> HOLD_R: symmetric to REQ-017 for right/move_right.
REQ-019 In HOLD_x the repeat counter SHALL increment every cycle; a pulse SHALL occur when it reaches REPEAT_DELAY-1 (first repeat, REPEAT_DELAY cycles after the initial pulse) and then every REPEAT_PERIOD cycles thereafter (counter reloads to REPEAT_DELAY-REPEAT_PERIOD on each repeat pulse).
REQ-020 HOLD_x -> IDLE when x stable falls; no pulse on that edge; repeat counter clears.
REQ-021 Both stable high (from any state, including simultaneous rise): FSM SHALL enter CONFLICT, emit no move pulses, clear repeat counter.
REQ-022 CONFLICT -> IDLE only when both left and right stable are low; a lone held button after conflict SHALL NOT pulse until re-pressed.
REQ-023 move_left and move_right SHALL never be high in the same cycle; drop_piece is independent of the move FSM.
REQ-024 All three outputs SHALL be driven directly from flops.

Reset
REQ-025 rst high SHALL immediately clear synchronizers, stable levels, all counters and all outputs, and force FSM to IDLE.
REQ-026 Reset mid-press: after rst release a still-held button SHALL be re-debounced from zero and produce its initial pulse at edge k+DEBOUNCE_CYCLES+1 relative to the first post-reset sampling edge k.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Clean drop press at edge 0, held 50 cycles -> drop_piece high only in the cycle after edge 5; no further pulses; none on release.
REQ-028 Left raw toggles 1,0,1,0 on successive edges then stays high from edge 10 -> no pulse before edge 15; single move_left after edge 15.
REQ-029 Right held 30 cycles after acceptance -> move_right at acceptance+1, then +10, +13, +16, +19, +22, +25, +28; stops within one cycle of stable falling.
REQ-030 Left and right raw rise on the same edge and hold -> no move pulses; release right only -> still none; release both then press left -> normal initial pulse.
REQ-031 rst asserted asynchronously mid repeat-hold with left held -> outputs 0 immediately; after release, move_left exactly once at edge k+5 and repeats resume per REQ-019.
